acq_sequencer: RTL

Sequences one acquisition run between the SPI register block and the sample FIFO. It takes the level controls `acq_enable`, `acq_reset`, `clock_select`, `clock_divisor` and `channel_enable` and turns them into three things: a timed FIFO flush, a sample strobe gated by the divisor, and a sticky overflow-halt. It sits in the normal clock domain, after the register file and before the sample capture/FIFO write path.

---
 rtl/acq_pkg.sv | 15 +
 rtl/clk_div_strobe.sv | 37 +++
 rtl/acq_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding, channel count
// and the default flush length.
package acq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } acq_state_e;

    localparam int unsigned ACQ_CHANNELS         = 16;
    localparam int unsigned ACQ_FLUSH_CYCLES_DEF = 4;

endpackage

// File: rtl/clk_div_strobe.sv
// Loadable down-counter producing a sample tick every divisor+1 enabled cycles,
// or every enabled cycle when bypassed.
module clk_div_strobe #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] divisor,
    input  logic             enable,
    input  logic             bypass,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // The divisor is latched with the load so reloads ignore later input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            div_q <= divisor;
            cnt_q <= divisor;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_q <= div_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign tick = enable && (bypass || (cnt_q == '0));

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: timed FIFO flush, divided sample strobe and sticky
// overflow halt. Define ACQ_SAMPLE_COUNT_EN to add the saturating sample_count_o.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = ACQ_FLUSH_CYCLES_DEF,
    parameter int unsigned DIV_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acq_enable_i,
    input  logic                    acq_reset_i,
    input  logic                    clock_select_i,
    input  logic [DIV_W-1:0]        clock_divisor_i,
    input  logic [ACQ_CHANNELS-1:0] channel_enable_i,
    input  logic                    fifo_full_i,
    output logic                    fifo_reset_o,
    output logic                    sample_stb_o,
    output logic [ACQ_CHANNELS-1:0] sample_mask_o,
    output logic                    running_o,
    output logic                    overflow_o,
    output logic [1:0]              state_o
`ifdef ACQ_SAMPLE_COUNT_EN
    ,
    output logic [31:0]             sample_count_o
`endif
);

    acq_state_e              state_q;
    logic [7:0]              flush_cnt_q;
    logic                    drop_q;
    logic                    acq_reset_q;
    logic                    overflow_q;
    logic                    sel_q;
    logic [ACQ_CHANNELS-1:0] mask_q;

    logic div_load;
    logic div_tick;
    logic strobe_cond;
    logic overflow_hit;

    assign div_load = (state_q == StFlush) && (flush_cnt_q == 8'd0) && !acq_reset_i;

    clk_div_strobe #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .load    (div_load),
        .divisor (clock_divisor_i),
        .enable  (state_q == StRun),
        .bypass  (sel_q),
        .tick    (div_tick)
    );

    assign strobe_cond  = div_tick && (mask_q != '0);
    assign overflow_hit = strobe_cond && fifo_full_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= 8'd0;
            drop_q      <= 1'b0;
            acq_reset_q <= 1'b0;
            overflow_q  <= 1'b0;
            sel_q       <= 1'b0;
            mask_q      <= '0;
        end else begin
            acq_reset_q <= acq_reset_i;
            if (acq_reset_i) begin
                state_q    <= StIdle;
                overflow_q <= 1'b0;
                drop_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (acq_enable_i) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= 8'(FLUSH_CYCLES - 1);
                            overflow_q  <= 1'b0;
                            drop_q      <= 1'b0;
                        end
                    end
                    StFlush: begin
                        if (!acq_enable_i) begin
                            drop_q <= 1'b1;
                        end
                        if (flush_cnt_q == 8'd0) begin
                            sel_q   <= clock_select_i;
                            mask_q  <= channel_enable_i;
                            // A request dropped at any point in the flush still lets it finish.
                            state_q <= (drop_q || !acq_enable_i) ? StIdle : StRun;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - 8'd1;
                        end
                    end
                    StRun: begin
                        if (overflow_hit) begin
                            state_q    <= StHalt;
                            overflow_q <= 1'b1;
                        end else if (!acq_enable_i) begin
                            state_q <= StIdle;
                        end
                    end
                    StHalt: begin
                        if (!acq_enable_i) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef ACQ_SAMPLE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || acq_reset_i || (state_q == StFlush)) begin
            count_q <= 32'd0;
        end else if (sample_stb_o && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign sample_count_o = count_q;
`endif

    assign fifo_reset_o  = (state_q == StFlush) || acq_reset_q;
    assign sample_stb_o  = strobe_cond && !fifo_full_i;
    assign sample_mask_o = mask_q;
    assign running_o     = (state_q == StRun);
    assign overflow_o    = overflow_q;
    assign state_o       = state_q;

endmodule
